// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM encodings, oversample dividers
// for a 100 MHz clock, and the default receive-buffer depth.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Clocks per 16x oversample tick at 100 MHz, rounded to nearest.
  localparam int OVS_DIV_115200 = 54;
  localparam int OVS_DIV_230400 = 27;
  localparam int OVS_DIV_460800 = 14;

  localparam int DEFAULT_FIFO_DEPTH = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small receive FIFO.
// Handshake: rx_data_valid is high while the FIFO holds data, rx_data shows the head entry, and a pop happens on every cycle with rx_data_valid && rx_data_ready.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int OVS_DIV    = OVS_DIV_230400,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_data_valid,
  input  logic                          rx_data_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output rx_state_t                     rx_state
);

  localparam int DIV_W = $clog2(OVS_DIV + 1);

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       settle_q, settle_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rx_s;
  logic             fall;
  logic             tick;

  rx_state_t        state_q;
  logic [3:0]       sub_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             stop_wait_q;
  logic             push_q;
  logic             frame_err_q;
  logic             overrun_q, overrun_d;

  logic             fifo_full;
  logic             fifo_empty;

  assign rx_s = sync2_q;
  assign tick = (div_q == DIV_W'(OVS_DIV - 1));

  // prev_q only reflects the real line once the synchronizer has been refilled
  // after reset, so a line held low through reset is not mistaken for a start edge.
  assign fall = (settle_q == 2'd3) && prev_q && !rx_s;

  always_comb begin
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    div_d    = tick ? '0 : div_q + 1'b1;
    if (state_q == ST_IDLE && fall) div_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      settle_q <= 2'd0;
      div_q    <= '0;
    end else begin
      sync1_q  <= rx_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      settle_q <= settle_d;
      div_q    <= div_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sub_q       <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      stop_wait_q <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q <= ST_START;
            sub_q   <= 4'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sub_q == 4'd7) begin
              // Mid start bit: a high line means the edge was only a glitch.
              if (!rx_s) begin
                state_q <= ST_DATA;
                sub_q   <= 4'd0;
                bit_q   <= 3'd0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              sub_q <= sub_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (sub_q == 4'd15) begin
              sub_q   <= 4'd0;
              shift_q <= {rx_s, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= ST_STOP;
            end else begin
              sub_q <= sub_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (stop_wait_q) begin
            if (rx_s) begin
              stop_wait_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else if (tick) begin
            if (sub_q == 4'd15) begin
              if (rx_s) begin
                push_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                stop_wait_q <= 1'b1;
              end
            end else begin
              sub_q <= sub_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // When full the FIFO is non-empty, so rx_data_ready alone decides whether a pop frees a slot.
  assign overrun_d = push_q && fifo_full && !rx_data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (rx_data_ready),
    .data_o  (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rx_data_valid = !fifo_empty;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign rx_state      = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames are bit-banged onto rx_in and
// the FIFO side is checked against hand-computed bytes, counts and pulse tallies.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  // Short divider keeps the run small; bit timing follows it exactly.
  localparam int OVS      = 8;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 16 * OVS;
  localparam int LIMIT    = 20 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       frame_err;
  logic       overrun;
  logic [3:0] fifo_count;
  rx_state_t  rx_state;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  bit saw_start = 1'b0;
  bit saw_data = 1'b0;

  uart_rx_fifo #(
    .OVS_DIV    (OVS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .fifo_count    (fifo_count),
    .rx_state      (rx_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (rx_state === ST_START) saw_start = 1'b1;
    if (rx_state === ST_DATA) saw_data = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx_in = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_val);
    if (!stop_val) send_bit(1'b1);
    rx_in = 1'b1;
  endtask

  task automatic do_pop();
    @(negedge clk);
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    rx_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (rx_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_data_valid); end
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_vec++; if (rx_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", rx_state, ST_IDLE); end
    reset = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_single();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'hA5, 1'b1);
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", rx_data); end
    n_vec++; if (rx_data_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rx_data_valid); end
    n_vec++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    n_vec++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    n_vec++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL single_overrun: got %0d pulses want 0", ov_cnt - ov0); end
    do_pop();
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
    wait_clks(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (rx_data !== exp_b[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rx_data, exp_b[i]); end
      n_vec++; if (fifo_count !== 4'(3 - i)) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, fifo_count, 3 - i); end
      rx_data_ready = 1'b1;
    end
    @(negedge clk);
    rx_data_ready = 1'b0;
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL b2b_final_count: got %0d want 0", fifo_count); end
    n_vec++; if (rx_data_valid !== 1'b0) begin n_err++; $display("FAIL b2b_final_valid: got %b want 0", rx_data_valid); end
  endtask

  task automatic test_frame_err();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h3C, 1'b0);
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL ferr_count: got %0d want 0", fifo_count); end
    n_vec++; if (rx_state !== ST_IDLE) begin n_err++; $display("FAIL ferr_state: got %0d want %0d", rx_state, ST_IDLE); end
    send_byte(8'h42, 1'b1);
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL ferr_next_count: got %0d want 1", fifo_count); end
    n_vec++; if (rx_data !== 8'h42) begin n_err++; $display("FAIL ferr_next_data: got %h want 42", rx_data); end
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL ferr_next_pulses: got %0d want 1", fe_cnt - fe0); end
    n_vec++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL ferr_overrun: got %0d want 0", ov_cnt - ov0); end
    do_pop();
  endtask

  task automatic test_overrun();
    int ov0, fe0, t;
    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (ov_cnt - ov0 !== 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - ov0); end
    n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovr_count: got %0d want 8", fifo_count); end
    n_vec++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL ovr_frame_err: got %0d want 0", fe_cnt - fe0); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_vec++; if (rx_data !== 8'(i)) begin n_err++; $display("FAIL ovr_pop[%0d]: got %h want %h", i, rx_data, 8'(i)); end
      do_pop();
    end
    @(negedge clk);
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL ovr_drain: got %0d want 0", fifo_count); end

    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    ov0 = ov_cnt;
    // The write lands on the edge after the FSM leaves STOP, so pop exactly then.
    fork
      send_byte(8'h09, 1'b1);
      begin
        t = 0;
        while (rx_state !== ST_STOP && t < LIMIT) begin @(negedge clk); t++; end
        while (rx_state !== ST_IDLE && t < LIMIT) begin @(negedge clk); t++; end
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
      end
    join
    n_vec++; if (t >= LIMIT) begin n_err++; $display("FAIL ovr_sync_timeout: waited %0d clocks, limit %0d", t, LIMIT); end
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL ovr_coincide_pulses: got %0d want 0", ov_cnt - ov0); end
    n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovr_coincide_count: got %0d want 8", fifo_count); end
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      n_vec++; if (rx_data !== 8'(i)) begin n_err++; $display("FAIL ovr_coincide_pop[%0d]: got %h want %h", i, rx_data, 8'(i)); end
      do_pop();
    end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    saw_start = 1'b0;
    saw_data = 1'b0;
    rx_in = 1'b0;
    repeat (3 * OVS) @(posedge clk);
    rx_in = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    n_vec++; if (saw_start !== 1'b1) begin n_err++; $display("FAIL glitch_start_seen: got %b want 1", saw_start); end
    n_vec++; if (saw_data !== 1'b0) begin n_err++; $display("FAIL glitch_data_seen: got %b want 0", saw_data); end
    n_vec++; if (rx_state !== ST_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want %0d", rx_state, ST_IDLE); end
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
    n_vec++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d want 0", (fe_cnt - fe0) + (ov_cnt - ov0)); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (fifo_count !== 4'd2) begin n_err++; $display("FAIL rmid_queued: got %0d want 2", fifo_count); end
    // 0x7E: start, then bits 0..2 = 0,1,1; reset lands inside bit 2.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_in = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (rx_state !== ST_DATA) begin n_err++; $display("FAIL rmid_in_data: got %0d want %0d", rx_state, ST_DATA); end
    reset = 1'b1;
    #1;
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
    n_vec++; if (rx_data_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", rx_data_valid); end
    n_vec++; if (rx_state !== ST_IDLE) begin n_err++; $display("FAIL rmid_state: got %0d want %0d", rx_state, ST_IDLE); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rmid_no_spurious: got %0d want 0", fifo_count); end
    fe0 = fe_cnt;
    send_byte(8'h81, 1'b1);
    wait_clks(4);
    @(negedge clk);
    n_vec++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL rmid_after_count: got %0d want 1", fifo_count); end
    n_vec++; if (rx_data !== 8'h81) begin n_err++; $display("FAIL rmid_after_data: got %h want 81", rx_data); end
    n_vec++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL rmid_after_frame_err: got %0d want 0", fe_cnt - fe0); end
    do_pop();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
